// File: rtl/rggen_indirect_register_window.sv
// Indirect register window: an index register plus a data register give
// bus access to a DEPTH-entry register array, with optional wait states,
// auto-incrementing index, out-of-range index errors and a flat readout
// of all entries for the hardware side.
module rggen_indirect_register_window #(
  parameter int                     ADDRESS_WIDTH  = 16,
  parameter logic [ADDRESS_WIDTH-1:0] INDEX_ADDRESS = 'h0,
  parameter logic [ADDRESS_WIDTH-1:0] DATA_ADDRESS  = 'h4,
  parameter int                     DATA_WIDTH     = 32,
  parameter int                     DEPTH          = 16,
  parameter int                     INDEX_WIDTH    = $clog2(DEPTH),
  parameter bit                     AUTO_INCREMENT = 1'b1,
  parameter int                     WAIT_CYCLES    = 0,
  parameter logic [DATA_WIDTH-1:0]  VALID_BITS     = '1,
  parameter logic [DATA_WIDTH-1:0]  INITIAL_VALUE  = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_request,
  input  logic [ADDRESS_WIDTH-1:0]    i_address,
  input  logic                        i_write,
  input  logic [DATA_WIDTH-1:0]       i_write_data,
  input  logic [DATA_WIDTH/8-1:0]     i_strobe,
  input  logic                        i_clear,
  output logic                        o_select,
  output logic                        o_ready,
  output logic                        o_error,
  output logic [DATA_WIDTH-1:0]       o_read_data,
  output logic [INDEX_WIDTH-1:0]      o_index,
  output logic [DEPTH*DATA_WIDTH-1:0] o_entries
);

  localparam int                     STRB_W    = DATA_WIDTH / 8;
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX  = INDEX_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH:0]    DEPTH_EXT = (DATA_WIDTH + 1)'(DEPTH);
  localparam logic [3:0]             WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_e;

  state_e                               state_q;
  logic [3:0]                           wait_cnt_q;
  logic                                 is_data_q;
  logic                                 write_q;
  logic [DATA_WIDTH-1:0]                wdata_q;
  logic [STRB_W-1:0]                    strobe_q;
  logic                                 ready_q;
  logic                                 error_q;
  logic [DATA_WIDTH-1:0]                rdata_q;
  logic [INDEX_WIDTH-1:0]               index_q, index_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     entry_q, entry_d;

  logic                  hit_index, hit_data, accept, index_oob, done;
  logic                  cur_data, cur_write;
  logic [DATA_WIDTH-1:0] entry_rd, rsp_data, wmask;

  assign hit_index = (i_address == INDEX_ADDRESS);
  assign hit_data  = (i_address == DATA_ADDRESS);
  assign o_select  = hit_index | hit_data;
  assign accept    = (state_q == ST_IDLE) && i_request && o_select;
  assign index_oob = ({1'b0, i_write_data} >= DEPTH_EXT);
  assign done      = (state_q == ST_RESPOND);
  assign entry_rd  = entry_q[index_q] & VALID_BITS;

  // In IDLE the access attributes come straight off the bus; in WAIT they
  // come from the copy latched at acceptance.
  assign cur_data  = (state_q == ST_IDLE) ? hit_data : is_data_q;
  assign cur_write = (state_q == ST_IDLE) ? i_write  : write_q;

  // Read data presented with the response: entry or zero-extended index
  always_comb begin
    rsp_data = '0;
    if (!cur_write) rsp_data = cur_data ? entry_rd : DATA_WIDTH'(index_q);
  end

  // Access FSM; response outputs are registered and live for the RESPOND cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      is_data_q  <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      strobe_q   <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      ready_q <= 1'b0;
      error_q <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            is_data_q <= hit_data;
            write_q   <= i_write;
            wdata_q   <= i_write_data;
            strobe_q  <= i_strobe;
            if (hit_data && (WAIT_CYCLES > 0)) begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end else begin
              state_q <= ST_RESPOND;
              ready_q <= 1'b1;
              error_q <= hit_index && i_write && index_oob;
              rdata_q <= rsp_data;
            end
          end
        end
        ST_WAIT: begin
          // an abandoned request leaves no trace
          if (!i_request) begin
            state_q <= ST_IDLE;
          end else if (wait_cnt_q == '0) begin
            state_q <= ST_RESPOND;
            ready_q <= 1'b1;
            rdata_q <= rsp_data;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_RESPOND: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  // Index update at the end of RESPOND; clear overrides everything
  always_comb begin
    index_d = index_q;
    if (done) begin
      if (!is_data_q) begin
        if (write_q && !error_q) index_d = wdata_q[INDEX_WIDTH-1:0];
      end else if (AUTO_INCREMENT) begin
        index_d = (index_q == LAST_IDX) ? '0 : index_q + 1'b1;
      end
    end
    if (i_clear) index_d = '0;
  end

  // Byte-enable mask restricted to implemented bits
  always_comb begin
    wmask = '0;
    for (int b = 0; b < STRB_W; b++) wmask[b*8 +: 8] = {8{strobe_q[b]}};
    wmask = wmask & VALID_BITS;
  end

  // Entry write at the end of RESPOND, into the entry the index pointed at
  always_comb begin
    entry_d = entry_q;
    if (done && is_data_q && write_q)
      entry_d[index_q] = (entry_q[index_q] & ~wmask) | (wdata_q & wmask);
  end

  // Index and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      entry_q <= {DEPTH{INITIAL_VALUE & VALID_BITS}};
    end else begin
      index_q <= index_d;
      entry_q <= entry_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_error     = error_q;
  assign o_read_data = rdata_q;
  assign o_index     = index_q;
  assign o_entries   = entry_q;

endmodule

// File: tb/tb_rggen_indirect_register_window.sv
// Scoreboard bench for the indirect register window: each access pushes its
// expected response, which is popped and compared when o_ready appears.
module tb_rggen_indirect_register_window;
  localparam int          AW    = 16;
  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam int          IW    = 4;
  localparam int          WAITC = 3;
  localparam logic [31:0] VB    = 32'h00FF00FF;
  localparam logic [31:0] INIT  = 32'h12345678;
  localparam logic [31:0] RSTV  = 32'h00340078;
  localparam logic [15:0] A_IDX = 16'h0;
  localparam logic [15:0] A_DAT = 16'h4;

  logic                  clk, rst_n;
  logic                  i_request, i_write, i_clear;
  logic [AW-1:0]         i_address;
  logic [DW-1:0]         i_write_data;
  logic [DW/8-1:0]       i_strobe;
  logic                  o_select, o_ready, o_error;
  logic [DW-1:0]         o_read_data;
  logic [IW-1:0]         o_index;
  logic [DEPTH*DW-1:0]   o_entries;

  rggen_indirect_register_window #(
    .ADDRESS_WIDTH(AW), .INDEX_ADDRESS(A_IDX), .DATA_ADDRESS(A_DAT),
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AUTO_INCREMENT(1'b1),
    .WAIT_CYCLES(WAITC), .VALID_BITS(VB), .INITIAL_VALUE(INIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_request(i_request), .i_address(i_address),
    .i_write(i_write), .i_write_data(i_write_data), .i_strobe(i_strobe),
    .i_clear(i_clear), .o_select(o_select), .o_ready(o_ready),
    .o_error(o_error), .o_read_data(o_read_data), .o_index(o_index),
    .o_entries(o_entries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        chk_rd;
    logic        err;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  logic [31:0] mem [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] entry(input int k);
    return o_entries[k*DW +: DW];
  endfunction

  // One bus access: push expectation, drive, pop and compare at o_ready.
  task automatic access(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic chk_rd, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input logic clr);
    exp_t e;
    int   t0;
    bit   got;
    e.rd = exp_rd; e.chk_rd = chk_rd; e.err = exp_err; e.lat = exp_lat;
    @(posedge clk); #1;
    i_request = 1'b1; i_address = addr; i_write = wr;
    i_write_data = wd; i_strobe = st;
    t0 = cyc;
    q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1'b1;
        e = q.pop_front();
        check({tag, "_lat"}, 64'(cyc - t0), 64'(e.lat));
        check({tag, "_err"}, 64'(o_error), 64'(e.err));
        if (e.chk_rd) check({tag, "_rdata"}, 64'(o_read_data), 64'(e.rd));
        if (clr) i_clear = 1'b1;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 64'(0), 64'(1));
      q.delete();
    end
    @(posedge clk); #1;
    i_request = 1'b0; i_write = 1'b0; i_clear = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    bit seen;
    rst_n = 1'b0; i_request = 1'b0; i_address = '0; i_write = 1'b0;
    i_write_data = '0; i_strobe = '0; i_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(o_ready), 64'(0));
    check("rst_rdata", 64'(o_read_data), 64'(0));
    check("rst_index", 64'(o_index), 64'(0));
    check("rst_entry0", 64'(entry(0)), 64'(RSTV));
    check("rst_entry15", 64'(entry(15)), 64'(RSTV));
    i_address = 16'h8; #1;
    check("sel_miss", 64'(o_select), 64'(0));
    i_address = A_DAT; #1;
    check("sel_data", 64'(o_select), 64'(1));
    @(negedge clk); rst_n = 1'b1;

    // basic reads
    access("rd_idx", A_IDX, 0, 0, 4'hF, 1, 32'h0, 0, 1, 0);
    access("rd_dat", A_DAT, 0, 0, 4'hF, 1, RSTV, 0, 1 + WAITC, 0);
    check("rd_dat_inc", 64'(o_index), 64'(1));

    // auto-increment wrap
    access("wr_idx14", A_IDX, 1, 32'd14, 4'hF, 0, 0, 0, 1, 0);
    check("idx14", 64'(o_index), 64'(14));
    access("wr_a", A_DAT, 1, 32'hA, 4'hF, 0, 0, 0, 1 + WAITC, 0);
    access("wr_b", A_DAT, 1, 32'hB, 4'hF, 0, 0, 0, 1 + WAITC, 0);
    access("wr_c", A_DAT, 1, 32'hC, 4'hF, 0, 0, 0, 1 + WAITC, 0);
    check("ent14", 64'(entry(14)), 64'(32'hA));
    check("ent15", 64'(entry(15)), 64'(32'hB));
    check("ent0", 64'(entry(0)), 64'(32'hC));
    check("wrap_idx", 64'(o_index), 64'(1));

    // out-of-range index write
    access("wr_idx16", A_IDX, 1, 32'd16, 4'h0, 0, 0, 1, 1, 0);
    check("oob_idx", 64'(o_index), 64'(1));

    // request dropped during wait, then unselected address
    @(posedge clk); #1;
    i_request = 1'b1; i_address = A_DAT; i_write = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); seen |= o_ready;
      @(posedge clk);
    end
    #1 i_request = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); seen |= o_ready; end
    check("drop_noready", 64'(seen), 64'(0));
    check("drop_idx", 64'(o_index), 64'(1));
    @(posedge clk); #1;
    i_request = 1'b1; i_address = 16'h8; i_write = 1'b1; i_write_data = 32'h3;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); seen |= o_ready; end
    #1 i_request = 1'b0; i_write = 1'b0;
    check("miss_noready", 64'(seen), 64'(0));
    check("miss_idx", 64'(o_index), 64'(1));

    // strobes and valid-bit masking
    access("wr_idx0", A_IDX, 1, 32'd0, 4'hF, 0, 0, 0, 1, 0);
    access("wr_strb", A_DAT, 1, 32'hFFFFFFFF, 4'b0101, 0, 0, 0, 1 + WAITC, 0);
    check("strb_ent0", 64'(entry(0)), 64'(32'h00FF00FF));
    access("wr_idx0b", A_IDX, 1, 32'd0, 4'hF, 0, 0, 0, 1, 0);
    access("rd_strb", A_DAT, 0, 0, 4'hF, 1, 32'h00FF00FF, 0, 1 + WAITC, 0);
    check("strb_idx", 64'(o_index), 64'(1));

    // clear coincident with a data write response
    access("wr_clr", A_DAT, 1, 32'h55, 4'hF, 0, 0, 0, 1 + WAITC, 1);
    check("clr_idx", 64'(o_index), 64'(0));
    check("clr_ent1", 64'(entry(1)), 64'(32'h55));
    check("clr_ent0", 64'(entry(0)), 64'(32'h00FF00FF));

    // random data through entries 2..5 and read back
    access("wr_idx2", A_IDX, 1, 32'd2, 4'hF, 0, 0, 0, 1, 0);
    for (int k = 2; k < 6; k++) begin
      v = $urandom;
      mem[k] = v & VB;
      access("wr_rnd", A_DAT, 1, v, 4'hF, 0, 0, 0, 1 + WAITC, 0);
    end
    access("rd_idx6", A_IDX, 0, 0, 4'hF, 1, 32'd6, 0, 1, 0);
    access("wr_idx2b", A_IDX, 1, 32'd2, 4'hF, 0, 0, 0, 1, 0);
    for (int k = 2; k < 6; k++)
      access("rd_rnd", A_DAT, 0, 0, 4'hF, 1, mem[k], 0, 1 + WAITC, 0);

    // reset during a pending data write
    access("wr_idx3", A_IDX, 1, 32'd3, 4'hF, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    i_request = 1'b1; i_address = A_DAT; i_write = 1'b1;
    i_write_data = 32'h00770077; i_strobe = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_ready", 64'(o_ready), 64'(0));
    check("mrst_idx", 64'(o_index), 64'(0));
    check("mrst_ent3", 64'(entry(3)), 64'(RSTV));
    i_request = 1'b0; i_write = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); seen |= o_ready; end
    check("mrst_noready", 64'(seen), 64'(0));
    check("mrst_ent3b", 64'(entry(3)), 64'(RSTV));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rggen_indirect_register_window.md
Name: rggen_indirect_register_window

Overview:
- Indirect register window: an index register and a data register together expose a DEPTH-entry internal register array through two bus addresses.
- Adds storage, multi-cycle wait states, auto-incrementing index, out-of-range error reporting and a hardware-side entry readout.
- Sits in the generated register block alongside the default and indirect registers, on the same register-level request/ready bus.

Parameters:
- ADDRESS_WIDTH, 16: bus address width.
- INDEX_ADDRESS, 'h0: word address of the index register.
- DATA_ADDRESS, 'h4: word address of the data register; must differ from INDEX_ADDRESS.
- DATA_WIDTH, 32: entry and bus data width; must be a multiple of 8.
- DEPTH, 16: number of entries; range 2 to 256.
- INDEX_WIDTH, $clog2(DEPTH): index pointer width (derived; do not override).
- AUTO_INCREMENT, 1: 1 = index advances after each completed data access.
- WAIT_CYCLES, 0: extra cycles before ready on data accesses; range 0 to 15.
- VALID_BITS, '1: implemented bits per entry; unimplemented bits always read 0 and are never written.
- INITIAL_VALUE, '0: reset value of every entry.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- i_request  input  1  bus request; held until o_ready.
- i_address  input  ADDRESS_WIDTH  bus word address.
- i_write  input  1  1 = write, 0 = read.
- i_write_data  input  DATA_WIDTH  write data.
- i_strobe  input  DATA_WIDTH/8  byte write enables.
- i_clear  input  1  synchronous clear of the index pointer to 0.
- o_select  output  1  address matches INDEX_ADDRESS or DATA_ADDRESS (combinational).
- o_ready  output  1  access complete; one-cycle pulse.
- o_error  output  1  error response; valid only with o_ready.
- o_read_data  output  DATA_WIDTH  read data; valid with o_ready, 0 otherwise.
- o_index  output  INDEX_WIDTH  current index pointer.
- o_entries  output  DEPTH*DATA_WIDTH  all entries, flattened; entry k at bits [k*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset: FSM = IDLE; o_ready, o_error, o_read_data = 0; index = 0; every entry = INITIAL_VALUE & VALID_BITS.
- FSM states and transitions:
  - IDLE → WAIT on a selected request when it is a data access and WAIT_CYCLES > 0; the wait counter loads WAIT_CYCLES-1.
  - IDLE → RESPOND on a selected request in all other cases.
  - WAIT decrements the counter and moves to RESPOND when the counter reaches 0.
  - RESPOND → IDLE unconditionally.
- Latency: o_ready is asserted in RESPOND only, exactly 1 cycle.
  - Index access: o_ready at request cycle +1.
  - Data access: o_ready at request cycle +1+WAIT_CYCLES.
  - At least one idle cycle separates consecutive accesses.
- Request dropped during WAIT: return to IDLE with no ready, no write and no index change.
- Index read: o_read_data = zero-extended index.
- Index write:
  - Write data ≥ DEPTH: o_error=1, index unchanged.
  - Otherwise: index = i_write_data[INDEX_WIDTH-1:0] at the RESPOND edge. Strobes are ignored for index writes.
- Data read: o_read_data = entry[index] & VALID_BITS, captured on entry to RESPOND.
- Data write: bytes with strobe=1 are written to entry[index], masked by VALID_BITS, at the RESPOND edge.
- Auto-increment (AUTO_INCREMENT=1): after each completed data access, index = index+1; DEPTH-1 wraps to 0. With AUTO_INCREMENT=0 the index holds.
- i_clear: forces index to 0 at the next edge and wins over an index write or an auto-increment in the same cycle. Does not affect entries.
- Address not matching either register: o_select=0, FSM stays IDLE, no response.
- Reset asserted mid-access: immediate return to reset state; the pending access is lost with no ready.

Test Plan:
- Reset then read index (addr 0x0) → o_ready at +1, o_read_data=0; read data (0x4) → INITIAL_VALUE, o_index becomes 1.
- DEPTH=16, AUTO_INCREMENT=1: write index 14, then write data 0xA, 0xB, 0xC → entries 14, 15, 0 hold 0xA, 0xB, 0xC; o_index ends at 1.
- Write index 16 with DEPTH=16 → o_ready with o_error=1; o_index unchanged.
- WAIT_CYCLES=3, data read → o_ready exactly 4 cycles after request; request dropped after 2 cycles → no ready, o_index unchanged.
- Data write 0xFFFFFFFF, strobe 4'b0101, VALID_BITS=0x00FF00FF, starting from entry 0 → entry = 0x00FF00FF; o_entries slice matches.
- i_clear asserted in the same cycle as a data-access ready → o_index=0, and the write still lands in the pre-clear entry.
